// File: rtl/sidi_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sidi_audio_pkg
// Description : Shared audio sample types and I2S framing mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sidi_audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    localparam int I2S_PHILIPS   = 1;
    localparam int I2S_LEFT_JUST = 0;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t left;
        audio_sample_t right;
    } stereo_sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clkgen
// Description : Bit-clock divider, frame bit counter, word select and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkgen
    import sidi_audio_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int SLOT_BITS = 32,
    parameter int I2S_MODE  = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic bck,
    output logic lrck,
    output logic bck_fall,
    output logic frame_wrap
);

    localparam int c_div_w      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_frame_bits = 2 * SLOT_BITS;
    localparam int c_cnt_w      = $clog2(c_frame_bits);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_slot     = c_cnt_w'(SLOT_BITS);
    localparam logic [c_cnt_w-1:0] c_slot_m1  = c_cnt_w'(SLOT_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_frame_m2 = c_cnt_w'(c_frame_bits - 2);

    logic [c_div_w-1:0] r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_bck;
    logic               r_lrck;
    logic               r_primed;
    logic               w_div_wrap;
    logic               w_fall;
    logic               w_lrck_next;

    assign w_div_wrap = (r_div == c_div_last);
    assign w_fall     = w_div_wrap & r_bck;

    // The first fall after reset is itself a frame boundary, so the opening
    // frame starts at bit 0 with a pair loaded at that fall.
    always_comb begin
        w_cnt_next = r_cnt + c_cnt_one;
        if (!r_primed || (r_cnt == c_cnt_last)) begin
            w_cnt_next = '0;
        end
    end

    generate
        if (I2S_MODE == I2S_PHILIPS) begin : g_lrck_philips
            assign w_lrck_next = (w_cnt_next >= c_slot_m1) && (w_cnt_next <= c_frame_m2);
        end else begin : g_lrck_left_just
            assign w_lrck_next = (w_cnt_next >= c_slot);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_bck    <= 1'b0;
            r_cnt    <= '0;
            r_lrck   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_div <= w_div_wrap ? '0 : (r_div + c_div_one);
            if (w_div_wrap) begin
                r_bck <= ~r_bck;
            end
            if (w_fall) begin
                r_cnt    <= w_cnt_next;
                r_lrck   <= w_lrck_next;
                r_primed <= 1'b1;
            end
        end
    end

    assign bck        = r_bck;
    assign lrck       = r_lrck;
    assign bck_fall   = w_fall;
    assign frame_wrap = w_fall & (w_cnt_next == '0);

endmodule
`default_nettype wire

// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_audio_tx
// Description : Stereo PCM to I2S serializer with one-entry holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_audio_tx
    import sidi_audio_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32,
    parameter int I2S_MODE  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                frame_start,
    output logic                underrun
);

    localparam int c_frame_bits = 2 * SLOT_BITS;

    logic                    w_bck_fall;
    logic                    w_frame_wrap;
    logic                    w_accept;
    logic                    w_hold_full_next;
    logic                    r_ready;
    logic                    r_hold_full;
    logic                    r_data;
    logic                    r_frame_start;
    logic                    r_underrun;
    logic [SAMPLE_W-1:0]     r_hold_l;
    logic [SAMPLE_W-1:0]     r_hold_r;
    logic [SAMPLE_W-1:0]     r_last_l;
    logic [SAMPLE_W-1:0]     r_last_r;
    logic [SAMPLE_W-1:0]     w_src_l;
    logic [SAMPLE_W-1:0]     w_src_r;
    logic [c_frame_bits-1:0] w_frame_lj;
    logic [c_frame_bits-1:0] w_frame;
    logic [c_frame_bits-1:0] r_shift;

    i2s_clkgen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS),
        .I2S_MODE  (I2S_MODE)
    ) u_clkgen (
        .clk        (clk),
        .reset_n    (reset_n),
        .bck        (i2s_bck),
        .lrck       (i2s_lrck),
        .bck_fall   (w_bck_fall),
        .frame_wrap (w_frame_wrap)
    );

    assign w_accept = in_valid & r_ready;
    assign w_src_l  = r_hold_full ? r_hold_l : r_last_l;
    assign w_src_r  = r_hold_full ? r_hold_r : r_last_r;

    // Whole frame laid out MSB-first: bit c_frame_bits-1 is sent at bit_cnt 0.
    assign w_frame_lj = ({{(c_frame_bits-SAMPLE_W){1'b0}}, w_src_l} << (c_frame_bits - SAMPLE_W))
                      | ({{(c_frame_bits-SAMPLE_W){1'b0}}, w_src_r} << (SLOT_BITS - SAMPLE_W));

    generate
        if (I2S_MODE == I2S_PHILIPS) begin : g_frame_philips
            assign w_frame = w_frame_lj >> 1;
        end else begin : g_frame_left_just
            assign w_frame = w_frame_lj;
        end
    endgenerate

    // A load empties the register; a same-edge accept refills it.
    always_comb begin
        w_hold_full_next = r_hold_full;
        if (w_frame_wrap) begin
            w_hold_full_next = 1'b0;
        end
        if (w_accept) begin
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready       <= 1'b0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_last_l      <= '0;
            r_last_r      <= '0;
            r_shift       <= '0;
            r_data        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_ready       <= ~w_hold_full_next;
            r_hold_full   <= w_hold_full_next;
            r_frame_start <= w_frame_wrap;
            r_underrun    <= w_frame_wrap & ~r_hold_full;
            if (w_accept) begin
                r_hold_l <= in_left;
                r_hold_r <= in_right;
            end
            if (w_frame_wrap) begin
                r_last_l <= w_src_l;
                r_last_r <= w_src_r;
                r_data   <= w_frame[c_frame_bits-1];
                r_shift  <= w_frame << 1;
            end else if (w_bck_fall) begin
                r_data   <= r_shift[c_frame_bits-1];
                r_shift  <= r_shift << 1;
            end
        end
    end

    assign in_ready    = r_ready;
    assign i2s_data    = r_data;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_audio_tx
// Description : Scoreboard bench driving a Philips and a left-justified DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_tx;
    import sidi_audio_pkg::*;

    localparam int CLK_DIV    = 2;
    localparam int SAMPLE_W   = 16;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int FRAME_CLK  = FRAME_BITS * 2 * CLK_DIV;
    localparam int FIRST_FALL = 2 * CLK_DIV;

    typedef struct {
        stereo_sample_t pair;
        bit             under;
    } exp_frame_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_left = '0;
    logic [SAMPLE_W-1:0] in_right = '0;
    logic rdy_a, bck_a, lrck_a, data_a, fs_a, ur_a;
    logic rdy_b, bck_b, lrck_b, data_b, fs_b, ur_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2s_audio_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .SLOT_BITS(SLOT_BITS), .I2S_MODE(1)) u_dut_i2s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_left(in_left), .in_right(in_right), .i2s_bck(bck_a), .i2s_lrck(lrck_a),
        .i2s_data(data_a), .frame_start(fs_a), .underrun(ur_a)
    );

    i2s_audio_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .SLOT_BITS(SLOT_BITS), .I2S_MODE(0)) u_dut_lj (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_left(in_left), .in_right(in_right), .i2s_bck(bck_b), .i2s_lrck(lrck_b),
        .i2s_data(data_b), .frame_start(fs_b), .underrun(ur_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected serial bit k of a frame, straight from the slot/position rule.
    function automatic logic [63:0] exp_data(input stereo_sample_t s, input int mode);
        logic [63:0]         v;
        logic [SAMPLE_W-1:0] smp;
        int                  p;
        v = '0;
        for (int k = 0; k < FRAME_BITS; k++) begin
            smp = (k < SLOT_BITS) ? s.left : s.right;
            p = (k % SLOT_BITS) - mode;
            if (p < 0) p += SLOT_BITS;
            if (p < SAMPLE_W) v[k] = smp[SAMPLE_W-1-p];
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_lrck(input int mode);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (mode == 1) v[k] = (k >= SLOT_BITS-1) && (k <= FRAME_BITS-2);
            else           v[k] = (k >= SLOT_BITS);
        end
        return v;
    endfunction

    // ---------------- reference model: frame loads on a fixed clock grid
    int unsigned    edge_n;
    bit             m_full, m_ready;
    stereo_sample_t m_hold, m_last;
    exp_frame_t     m_f;
    exp_frame_t     q0[$];
    exp_frame_t     q1[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_n  = 0;
            m_full  = 0;
            m_ready = 0;
            m_hold  = '0;
            m_last  = '0;
            q0.delete();
            q1.delete();
        end else begin
            edge_n++;
            if (edge_n >= FIRST_FALL && ((edge_n - FIRST_FALL) % FRAME_CLK) == 0) begin
                m_f.under = !m_full;
                m_f.pair  = m_full ? m_hold : m_last;
                m_last    = m_f.pair;
                m_full    = 0;
                q0.push_back(m_f);
                q1.push_back(m_f);
            end
            if (in_valid && m_ready) begin
                m_hold = {in_left, in_right};
                m_full = 1;
            end
            m_ready = !m_full;
        end
    end

    // ---------------- monitor: rebuilds each frame from BCK falls
    bit          prev_bck[2], prev_data[2], prev_lrck[2];
    bit          have_exp[2], bad_stab[2], bad_pulse[2], bad_period[2];
    int          falls[2], since_fall[2];
    logic [63:0] dvec[2], lvec[2];
    exp_frame_t  cur[2];

    task automatic mon_reset(input int id);
        prev_bck[id] = 0; prev_data[id] = 0; prev_lrck[id] = 0;
        have_exp[id] = 0; bad_stab[id] = 0; bad_pulse[id] = 0; bad_period[id] = 0;
        falls[id] = 0; since_fall[id] = 0;
        dvec[id] = '0; lvec[id] = '0;
    endtask

    task automatic mon_step(input int id, input logic bck, input logic d, input logic lr,
                            input logic fs, input logic ur);
        string tag;
        int    k;
        int    mode;
        bit    fall;
        tag  = (id == 0) ? "i2s" : "lj";
        mode = (id == 0) ? 1 : 0;
        fall = prev_bck[id] && (bck === 1'b0);
        since_fall[id]++;
        if (!fall) begin
            if (d !== prev_data[id] || lr !== prev_lrck[id]) bad_stab[id] = 1;
            if (fs !== 1'b0 || ur !== 1'b0) bad_pulse[id] = 1;
        end else begin
            if (falls[id] > 0 && since_fall[id] != 2 * CLK_DIV) bad_period[id] = 1;
            since_fall[id] = 0;
            k = falls[id] % FRAME_BITS;
            falls[id]++;
            if (k == 0) begin
                have_exp[id] = 0;
                if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_frame_queue: actual frame boundary required none pending", tag);
                end else begin
                    if (id == 0) cur[id] = q0.pop_front();
                    else         cur[id] = q1.pop_front();
                    have_exp[id] = 1;
                    check($sformatf("%s_frame_start", tag), {63'd0, fs}, 64'd1);
                    check($sformatf("%s_underrun", tag), {63'd0, ur}, {63'd0, cur[id].under});
                end
            end else if (fs !== 1'b0 || ur !== 1'b0) begin
                bad_pulse[id] = 1;
            end
            dvec[id][k] = d;
            lvec[id][k] = lr;
            if (k == FRAME_BITS - 1 && have_exp[id]) begin
                check($sformatf("%s_data", tag), dvec[id], exp_data(cur[id].pair, mode));
                check($sformatf("%s_lrck", tag), lvec[id], exp_lrck(mode));
                check($sformatf("%s_timing_flags", tag),
                      {61'd0, bad_stab[id], bad_pulse[id], bad_period[id]}, 64'd0);
                bad_stab[id] = 0; bad_pulse[id] = 0; bad_period[id] = 0;
            end
        end
        prev_bck[id]  = bck;
        prev_data[id] = d;
        prev_lrck[id] = lr;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_reset(0);
            mon_reset(1);
        end else begin
            check("i2s_in_ready", {63'd0, rdy_a}, {63'd0, m_ready});
            check("lj_in_ready", {63'd0, rdy_b}, {63'd0, m_ready});
            mon_step(0, bck_a, data_a, lrck_a, fs_a, ur_a);
            mon_step(1, bck_b, data_b, lrck_b, fs_b, ur_b);
        end
    end

    // ---------------- stimulus
    task automatic send(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r, input bit drop);
        bit got;
        got      = 0;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        for (int i = 0; i < 3 * FRAME_CLK && !got; i++) begin
            got = rdy_a;
            @(negedge clk);
        end
        if (drop) in_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: actual no accept required accept of %h/%h", l, r);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_i2s"}, {58'd0, rdy_a, bck_a, lrck_a, data_a, fs_a, ur_a}, 64'd0);
        check({name, "_lj"},  {58'd0, rdy_b, bck_b, lrck_b, data_b, fs_b, ur_b}, 64'd0);
    endtask

    initial begin
        bit found;
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        check_all_zero("reset_outputs");
        reset_n = 1'b1;
        repeat (FRAME_CLK + 20) @(negedge clk);

        send(16'hA5C3, 16'h8001, 1);
        repeat (2 * FRAME_CLK) @(negedge clk);
        send(16'h1234, 16'h5678, 1);
        repeat (2 * FRAME_CLK) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(16'(16'h0100 + i), 16'(16'hF000 + i), 0);
        end
        in_valid = 1'b0;
        repeat (FRAME_CLK) @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 400)) @(negedge clk);
            send(16'($urandom), 16'($urandom), 1);
        end
        repeat (FRAME_CLK) @(negedge clk);

        found = 0;
        for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
            @(negedge clk);
            found = fs_a;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_start_wait: actual none required pulse within bound");
        end
        repeat (20 * 2 * CLK_DIV) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_all_zero("midframe_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send(16'hBEEF, 16'h7F00, 1);
        repeat (3 * FRAME_CLK) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
